// File: rtl/instr_assembler.sv
// MIPS field-tuple assembler: packs R/I/J fields into 32-bit words and queues
// them, each tagged with a sequential word address, for an IM loader stream.
module instr_assembler #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               fmt,
    input  logic [5:0]               op,
    input  logic [4:0]               rs,
    input  logic [4:0]               rt,
    input  logic [4:0]               rd,
    input  logic [4:0]               shamt,
    input  logic [5:0]               funct,
    input  logic [15:0]              imm,
    input  logic [25:0]              imm1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err,
    input  logic                     err_clr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_addr  [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   next_addr_q;
    logic          err_q;

    logic [31:0]   enc_word;
    logic          reserved;
    logic          accept;
    logic          push;
    logic          pop;

    // Pack the fields selected by fmt; unused fields never reach the word.
    always_comb begin
        enc_word = '0;
        case (fmt)
            2'b00:   enc_word = {op, rs, rt, rd, shamt, funct};
            2'b01:   enc_word = {op, rs, rt, imm};
            2'b10:   enc_word = {op, imm1};
            default: enc_word = '0;
        endcase
    end

    assign reserved  = (fmt == 2'b11);
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready;
    // flush overrides both sides of the FIFO in its cycle.
    assign push      = accept && !reserved && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign out_instr = out_valid ? mem_instr[rd_ptr_q] : '0;
    assign out_addr  = out_valid ? mem_addr[rd_ptr_q]  : '0;
    assign count     = count_q;
    assign err       = err_q;

    // Pointers, occupancy and address counter; full/empty come from count only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            next_addr_q <= BASE_ADDR;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            next_addr_q <= BASE_ADDR;
        end else begin
            if (push) begin
                wr_ptr_q    <= wr_ptr_q + PW'(1);
                next_addr_q <= next_addr_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky reserved-format flag; a reserved accept beats err_clr, flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (!flush) begin
            if (accept && reserved) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr_q] <= enc_word;
            mem_addr[wr_ptr_q]  <= next_addr_q;
        end
    end

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Inverse of the instruction field splitter: packs MIPS field tuples (R/I/J format) into 32-bit instruction words.
- Buffers the packed words in a small FIFO, each tagged with a sequential word address.
- Feeds an instruction-memory loader or test stub through a valid/ready stream.
- Sits between the program/test-vector source and the IM write port.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
BASE_ADDR, 32'h0000_3000, address assigned to the first word after reset or flush

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of FIFO and address counter
in_valid  in  1  field tuple valid
in_ready  out  1  assembler can accept a tuple
fmt  in  2  format: 00 R, 01 I, 10 J, 11 reserved
op  in  6  opcode, bits [31:26]
rs  in  5  bits [25:21] (R, I)
rt  in  5  bits [20:16] (R, I)
rd  in  5  bits [15:11] (R)
shamt  in  5  bits [10:6] (R)
funct  in  6  bits [5:0] (R)
imm  in  16  bits [15:0] (I)
imm1  in  26  bits [25:0] (J)
out_valid  out  1  head word valid
out_ready  in  1  consumer accepts head word
out_instr  out  32  head instruction word
out_addr  out  32  head word address
count  out  $clog2(DEPTH)+1  current occupancy
err  out  1  sticky flag: reserved fmt was accepted
err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (async assert, sync release):
  - count=0, out_valid=0, in_ready=1, err=0.
  - out_instr=0, out_addr=0, next address = BASE_ADDR.
- Accept: in_valid && in_ready at a rising edge. in_ready = (count != DEPTH). No pass-through when full, even if a pop occurs in the same cycle.
- Encoding at accept:
  - R: {op,rs,rt,rd,shamt,funct}
  - I: {op,rs,rt,imm}
  - J: {op,imm1}
  - Fields not used by the selected format are ignored.
- Entry write: the encoded word and the current next address are written together. next address += 4, wrapping modulo 2^32.
- Reserved fmt (11): handshake completes, nothing is written, address is not advanced, err is set to 1.
- err stays set until err_clr or reset. If err_clr and a reserved accept fall in the same cycle, err=1 (set wins).
- Output:
  - out_valid = (count != 0).
  - out_instr/out_addr show the head entry, and read 0 when out_valid=0.
  - Pop on out_valid && out_ready.
  - While out_valid && !out_ready, out_instr/out_addr must hold stable.
- Latency: a tuple accepted at edge N into an empty FIFO gives out_valid=1 and the word on out_instr in the cycle after edge N. This is 1 cycle, with no combinational in->out path.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, order preserved.
- Pointers: read/write pointers wrap at DEPTH. Full/empty is derived from count only.
- flush:
  - Beats push, pop and err_clr.
  - Next edge: count=0, pointers=0, next address=BASE_ADDR.
  - A tuple presented in the flush cycle is discarded and does not affect err.
  - err is unaffected by flush.
- Reset mid-stream drops all entries immediately, without waiting for a clock edge.

Test Plan:
- R-type add $t0,$t1,$t2 (fmt=00, op=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20), out_ready=1 -> next cycle out_valid=1, out_instr=0x012A4020, out_addr=0x00003000.
- I-type ori $t0,$zero,0x1234 (fmt=01, op=0x0D, rs=0, rt=8, imm=0x1234) followed by J-type j (fmt=10, op=2, imm1=0x0000C00), back-to-back -> words 0x34081234 @0x3000 and 0x08000C00 @0x3004, in order.
- Backpressure, out_ready=0, five valid tuples:
  - Required: four accepted; count=4; in_ready=0 on the fifth, which is held.
  - Then out_ready=1: addresses 0x3000, 0x3004, 0x3008, 0x300C drain, then the fifth is accepted at 0x3010.
  - Head stays stable while stalled.
- fmt=11 tuple between two valid R-types:
  - Required: err=1 from the next cycle; only two words out, at 0x3000 and 0x3004.
  - err_clr pulse -> err=0.
- Flush with count=3 -> count=0, out_valid=0 next cycle; the next accepted word gets out_addr=0x3000.
- rst_n low for half a cycle while count=2 -> out_valid=0, count=0, in_ready=1 asynchronously; after release the first word gets 0x3000.
